// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: operator codes and FSM state type for the string-transform unit.
package cv32e40p_pkg;
  localparam int STR_OP_WIDTH = 3;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} str_state_e;
endpackage

// File: rtl/cv32e40p_str_byte_xlat.sv
// cv32e40p_str_byte_xlat: combinational per-byte ASCII transform with change flag.
module cv32e40p_str_byte_xlat
  import cv32e40p_pkg::*;
(
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [7:0]              byte_i,
  output logic [7:0]              byte_o,
  output logic                    changed_o
);
  logic       is_up, is_lo, alpha;
  logic [7:0] lc, base, idx, rot, leet;
  always_comb begin
    is_up     = byte_i >= 8'h41 && byte_i <= 8'h5A;
    is_lo     = byte_i >= 8'h61 && byte_i <= 8'h7A;
    alpha     = is_up | is_lo;
    lc        = byte_i | 8'h20;
    base      = is_up ? 8'h41 : 8'h61;
    idx       = byte_i - base;
    rot       = base + (idx < 8'd13 ? idx + 8'd13 : idx - 8'd13);
    leet      = lc == 8'h61 ? 8'h34 : lc == 8'h65 ? 8'h33 : lc == 8'h69 ? 8'h31 :
                lc == 8'h6F ? 8'h30 : lc == 8'h73 ? 8'h35 : lc == 8'h74 ? 8'h37 : byte_i;
    byte_o    = operator_i == STR_OP_UPPER && is_lo ? byte_i - 8'h20 :
                operator_i == STR_OP_LOWER && is_up ? byte_i + 8'h20 :
                operator_i == STR_OP_LEET  && alpha ? leet :
                operator_i == STR_OP_ROT13 && alpha ? rot : byte_i;
    changed_o = byte_o != byte_i;
  end
endmodule

// File: rtl/cv32e40p_str_unit.sv
// cv32e40p_str_unit: iterative LANES-bytes-per-cycle string transform with valid/ready on both sides.
module cv32e40p_str_unit
  import cv32e40p_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic [DATA_WIDTH/8-1:0] mask_o
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int NCYC = NB / LANES;
  localparam int CW   = NCYC > 1 ? $clog2(NCYC) : 1;

  str_state_e              state_q;
  logic [STR_OP_WIDTH-1:0] op_q;
  logic [CW-1:0]           chunk_q;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NB-1:0]           mask_q, mask_d;
  logic                    valid_q;
  logic [7:0]              x_in [LANES];
  logic [7:0]              x_out [LANES];
  logic                    x_chg [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign x_in[g] = data_q[(int'(chunk_q) * LANES + g) * 8 +: 8];
    cv32e40p_str_byte_xlat u_xlat (
      .operator_i(op_q),
      .byte_i    (x_in[g]),
      .byte_o    (x_out[g]),
      .changed_o (x_chg[g])
    );
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    for (int l = 0; l < LANES; l++) begin
      data_d[(int'(chunk_q) * LANES + l) * 8 +: 8] = x_out[l];
      mask_d[int'(chunk_q) * LANES + l]             = mask_q[int'(chunk_q) * LANES + l] | x_chg[l];
    end
  end

  // In DONE the unit can take a new request exactly when the result is consumed.
  assign ready_o  = state_q == IDLE ? 1'b1 : state_q == DONE ? ready_i : 1'b0;
  assign valid_o  = valid_q;
  assign result_o = data_q;
  assign mask_o   = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      chunk_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if ((state_q == IDLE && valid_i) || (state_q == DONE && ready_i && valid_i)) begin
      state_q <= BUSY;
      op_q    <= operator_i;
      data_q  <= operand_i;
      mask_q  <= '0;
      chunk_q <= '0;
      valid_q <= 1'b0;
    end else if (state_q == BUSY) begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      chunk_q <= chunk_q + CW'(1);
      if (chunk_q == CW'(NCYC - 1)) begin
        state_q <= DONE;
        valid_q <= 1'b1;
      end
    end else if (state_q == DONE && ready_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cv32e40p_str_unit.sv
// tb_cv32e40p_str_unit: directed and random checks of the string unit against a character-level model.
module tb_cv32e40p_str_unit;
  import cv32e40p_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_i, flush_i, valid4_i;
  logic [2:0]  operator_i;
  logic [31:0] operand_i;
  logic        ready_o, valid_o, ready4_o, valid4_o;
  logic [31:0] result_o, result4_o;
  logic [3:0]  mask_o, mask4_o;
  int          checks = 0, errors = 0;

  cv32e40p_str_unit #(.DATA_WIDTH(32), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .operator_i(operator_i),
    .operand_i(operand_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .mask_o(mask_o)
  );
  cv32e40p_str_unit #(.DATA_WIDTH(32), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid4_i), .ready_o(ready4_o), .operator_i(operator_i),
    .operand_i(operand_i), .flush_i(flush_i), .valid_o(valid4_o), .ready_i(1'b1),
    .result_o(result4_o), .mask_o(mask4_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [2:0] op, input logic [7:0] c);
    int  i;
    bit  up, lo;
    i  = int'(c);
    up = c >= "A" && c <= "Z";
    lo = c >= "a" && c <= "z";
    case (op)
      STR_OP_UPPER: return lo ? 8'(i - 32) : c;
      STR_OP_LOWER: return up ? 8'(i + 32) : c;
      STR_OP_LEET:
        case (c)
          "A", "a": return "4";
          "E", "e": return "3";
          "I", "i": return "1";
          "O", "o": return "0";
          "S", "s": return "5";
          "T", "t": return "7";
          default:  return c;
        endcase
      STR_OP_ROT13: return up ? 8'(65 + (i - 65 + 13) % 26) : lo ? 8'(97 + (i - 97 + 13) % 26) : c;
      default:      return c;
    endcase
  endfunction

  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] w);
    logic [31:0] r;
    logic [3:0]  m;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = ref_byte(op, w[b*8 +: 8]);
      m[b]        = r[b*8 +: 8] != w[b*8 +: 8];
    end
    return {m, r};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] w);
    chk("ready_before_issue", ready_o, 1'b1);
    operator_i = op;
    operand_i  = w;
    valid_i    = 1'b1;
    @(negedge clk);
    valid_i    = 1'b0;
    operator_i = 3'($urandom);
    operand_i  = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_op(input logic [31:0] er, input logic [3:0] em, input string tag);
    int n;
    wait_valid(n);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_result"}, result_o, er);
    chk({tag, "_mask"}, mask_o, em);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, "_valid_drop"}, valid_o, 1'b0);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [2:0]  op;
    logic [31:0] w;
    logic [35:0] e;
    rst_n = 1'b1; valid_i = 0; ready_i = 0; flush_i = 0; valid4_i = 0;
    operator_i = '0; operand_i = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_mask", mask_o, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(STR_OP_UPPER, 32'h5A636261);
    finish_op(32'h5A434241, 4'b0111, "upper_abcZ");
    issue(STR_OP_ROT13, 32'h7A6E6D61);
    finish_op(32'h6D617A6E, 4'b1111, "rot13_amnz");
    issue(STR_OP_LOWER, 32'h2131305B);
    finish_op(32'h2131305B, 4'b0000, "lower_nonalpha");
    issue(STR_OP_LEET, 32'h74736574);
    finish_op(32'h37353337, 4'b1111, "leet_test");
    issue(3'd6, 32'h5A636261);
    finish_op(32'h5A636261, 4'b0000, "unknown_op");

    operator_i = STR_OP_LEET; operand_i = 32'h74736574; valid4_i = 1'b1;
    @(negedge clk);
    valid4_i = 1'b0;
    n = 0;
    while (!valid4_o && n < 20) begin @(negedge clk); n++; end
    chk("lanes4_latency", n, 1);
    chk("lanes4_result", result4_o, 32'h37353337);
    chk("lanes4_mask", mask4_o, 4'b1111);
    @(negedge clk);

    issue(STR_OP_UPPER, 32'h5A636261);
    wait_valid(n);
    repeat (3) begin
      chk("bp_valid", valid_o, 1'b1);
      chk("bp_ready", ready_o, 1'b0);
      chk("bp_result", result_o, 32'h5A434241);
      chk("bp_mask", mask_o, 4'b0111);
      @(negedge clk);
    end
    operator_i = STR_OP_ROT13; operand_i = 32'h7A6E6D61; valid_i = 1'b1; ready_i = 1'b1;
    #1 chk("b2b_ready", ready_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    chk("b2b_busy", ready_o, 1'b0);
    finish_op(32'h6D617A6E, 4'b1111, "b2b_rot13");

    issue(STR_OP_LEET, 32'h74736574);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_idle_ready", ready_o, 1'b1);
    seen = 0;
    repeat (8) begin seen |= valid_o; @(negedge clk); end
    chk("flush_no_valid", seen, 1'b0);
    issue(STR_OP_UPPER, 32'h5A636261);
    finish_op(32'h5A434241, 4'b0111, "after_flush");

    flush_i = 1'b1; valid_i = 1'b1; operator_i = STR_OP_UPPER; operand_i = 32'h61616161;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_idle_ignores", ready_o, 1'b1);
    seen = 0;
    repeat (6) begin seen |= valid_o; @(negedge clk); end
    chk("flush_idle_no_valid", seen, 1'b0);

    issue(STR_OP_UPPER, 32'h5A636261);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1'b1);
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_result", result_o, 32'h0);
    chk("midrst_mask", mask_o, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(STR_OP_UPPER, 32'h5A636261);
    finish_op(32'h5A434241, 4'b0111, "after_reset");

    for (int t = 0; t < 24; t++) begin
      op = 3'($urandom_range(0, 5));
      for (int b = 0; b < 4; b++)
        w[b*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'h41, 8'h7A));
      e = model(op, w);
      issue(op, w);
      finish_op(e[31:0], e[35:32], "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
